// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_ctrl_pkg                                                  |
// | Description : Shared MDU op encodings, FSM state type, D-stage predicate.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mdu_ctrl_pkg;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that open a busy window (mult/multu/div/divu occupy codes 0..3).
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // D-stage class test: SPECIAL opcode with an MDU funct field.
    function automatic logic d_is_md_instr(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == 6'h00) &&
               ((funct == 6'h10) || (funct == 6'h11) || (funct == 6'h12) || (funct == 6'h13) ||
                (funct == 6'h18) || (funct == 6'h19) || (funct == 6'h1A) || (funct == 6'h1B));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_ctrl_if                                                   |
// | Description : E-stage/D-stage handshake between pipeline and MDU.          |
// |               cancel exists only when MDU_CANCEL_EN is defined.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mdu_ctrl_if;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_use_md;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_CANCEL_EN
    logic        cancel;

    modport master (output e_start, e_op, e_a, e_b, d_use_md, cancel,
                    input  busy, stall_d, hi, lo);
    modport slave  (input  e_start, e_op, e_a, e_b, d_use_md, cancel,
                    output busy, stall_d, hi, lo);
`else
    modport master (output e_start, e_op, e_a, e_b, d_use_md,
                    input  busy, stall_d, hi, lo);
    modport slave  (input  e_start, e_op, e_a, e_b, d_use_md,
                    output busy, stall_d, hi, lo);
`endif
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_core                                                      |
// | Description : Combinational 64-bit mult/div result and divide-by-zero flag.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdu_core
    import mdu_ctrl_pkg::*;
(
    input  wire logic [2:0]  i_op,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [63:0] o_result,
    output logic             o_div_zero
);

    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic               w_b_zero;
    logic               w_ovf;
    logic        [31:0] w_sdiv_b;
    logic        [31:0] w_udiv_b;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquo;
    logic        [31:0] w_urem;

    assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    assign w_b_zero = (i_b == 32'd0);
    // Most-negative / -1 overflows; dividing by 1 yields the required 0x80000000 rem 0.
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_sdiv_b = (w_b_zero || w_ovf) ? 32'd1 : i_b;
    assign w_udiv_b = w_b_zero ? 32'd1 : i_b;

    assign w_squo = $signed(i_a) / $signed(w_sdiv_b);
    assign w_srem = $signed(i_a) % $signed(w_sdiv_b);
    assign w_uquo = i_a / w_udiv_b;
    assign w_urem = i_a % w_udiv_b;

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            c_OP_MULT:  o_result = w_smul;
            c_OP_MULTU: o_result = w_umul;
            c_OP_DIV:   o_result = {w_srem, w_squo};
            c_OP_DIVU:  o_result = {w_urem, w_uquo};
            default:    o_result = 64'd0;
        endcase
    end

    assign o_div_zero = w_b_zero && ((i_op == c_OP_DIV) || (i_op == c_OP_DIVU));

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_ctrl                                                      |
// | Description : Multi-cycle mult/div scheduler, HI/LO owner, D-stage stall.  |
// |               Optional abort input enabled by MDU_CANCEL_EN.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input wire logic clk,
    input wire logic reset,
    mdu_ctrl_if.slave bus
);

    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES);

    mdu_state_e  r_state;
    mdu_state_e  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic        w_cancel;
    logic        w_accept;
    logic        w_abort;
    logic        w_wb;
    logic        w_mthi;
    logic        w_mtlo;
    logic [63:0] w_result;
    logic        w_div_zero;

`ifdef MDU_CANCEL_EN
    assign w_cancel = bus.cancel;
`else
    assign w_cancel = 1'b0;
`endif

    mdu_core u_core (
        .i_op       (bus.e_op),
        .i_a        (bus.e_a),
        .i_b        (bus.e_b),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_wb        = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.e_start && !w_cancel) begin
                    if (is_muldiv(bus.e_op)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else if (bus.e_op == c_OP_MTHI) begin
                        w_mthi = 1'b1;
                    end else if (bus.e_op == c_OP_MTLO) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Cancel outranks the final-count writeback.
                if (w_cancel) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_wb        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= is_muldiv(bus.e_op) && bus.e_op[1] ? c_DIV_LOAD : c_MULT_LOAD;
            r_pend_hi <= w_result[63:32];
            r_pend_lo <= w_result[31:0];
            r_pend_wr <= !w_div_zero;
        end else if (w_abort) begin
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_wb && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_mthi) begin
                r_hi <= bus.e_a;
            end
            if (w_mtlo) begin
                r_lo <= bus.e_a;
            end
        end
    end

    assign bus.busy    = (r_state == ST_RUN);
    assign bus.stall_d = bus.d_use_md & (bus.busy | (bus.e_start & is_muldiv(bus.e_op)));
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mdu_ctrl                                                   |
// | Description : Self-checking bench: vector table, corner sequences, random  |
// |               ops against an arithmetic model. MDU_CANCEL_EN adds cancel.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if mif ();

    mdu_ctrl #(.MULT_CYCLES(c_MULT), .DIV_CYCLES(c_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        duse;
        logic [31:0] xhi;
        logic [31:0] xlo;
        int          ncyc;
    } vec_t;

    vec_t        vecs [10];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] xhi, output logic [31:0] xlo, output int ncyc);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          sp;
        longint unsigned up;
        xhi  = m_hi;
        xlo  = m_lo;
        ncyc = 0;
        case (op)
            3'd0: begin sp = sa * sb; xhi = sp[63:32]; xlo = sp[31:0]; ncyc = c_MULT; end
            3'd1: begin up = ua * ub; xhi = up[63:32]; xlo = up[31:0]; ncyc = c_MULT; end
            3'd2: begin
                ncyc = c_DIV;
                if (b != 0) begin
                    sp = sa / sb; xlo = sp[31:0];
                    sp = sa % sb; xhi = sp[31:0];
                end
            end
            3'd3: begin
                ncyc = c_DIV;
                if (b != 0) begin
                    up = ua / ub; xlo = up[31:0];
                    up = ua % ub; xhi = up[31:0];
                end
            end
            3'd4: xhi = a;
            3'd5: xlo = a;
            default: ;
        endcase
    endtask

    // Issue one op at a settled point mid-cycle and follow it to completion.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic duse, input logic [31:0] xhi,
                          input logic [31:0] xlo, input int ncyc);
        logic exp_stall;
        exp_stall = duse && (op <= 3'd3);
        mif.e_start  = 1'b1;
        mif.e_op     = op;
        mif.e_a      = a;
        mif.e_b      = b;
        mif.d_use_md = duse;
        #1;
        chk({tag, " start stall"}, 32'(mif.stall_d), 32'(exp_stall));
        chk({tag, " start busy"}, 32'(mif.busy), 32'd0);
        @(posedge clk); #1;
        mif.e_start = 1'b0;
        mif.e_a     = $urandom;
        mif.e_b     = $urandom;
        #1;
        for (int i = 0; i < ncyc; i++) begin
            chk($sformatf("%s busy c%0d", tag, i), 32'(mif.busy), 32'd1);
            chk($sformatf("%s stall c%0d", tag, i), 32'(mif.stall_d), 32'(duse));
            chk($sformatf("%s hi stable c%0d", tag, i), mif.hi, m_hi);
            chk($sformatf("%s lo stable c%0d", tag, i), mif.lo, m_lo);
            @(posedge clk); #2;
        end
        chk({tag, " done busy"}, 32'(mif.busy), 32'd0);
        chk({tag, " done stall"}, 32'(mif.stall_d), 32'd0);
        chk({tag, " hi"}, mif.hi, xhi);
        chk({tag, " lo"}, mif.lo, xlo);
        m_hi = xhi;
        m_lo = xlo;
        mif.d_use_md = 1'b0;
    endtask

    initial begin
        logic [31:0] rhi, rlo, ra, rb;
        logic [2:0]  rop;
        logic [5:0]  funct;
        int          rcyc;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          1'b0, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{3'd5, 32'd2,         32'd0,          1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 0};
        vecs[4] = '{3'd4, 32'd1,         32'd0,          1'b0, 32'h0000_0001, 32'h0000_0002, 0};
        vecs[5] = '{3'd3, 32'd7,         32'd0,          1'b1, 32'h0000_0001, 32'h0000_0002, 10};
        vecs[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[7] = '{3'd6, 32'hDEAD_BEEF, 32'd5,          1'b1, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[8] = '{3'd4, 32'h1234_5678, 32'd0,          1'b1, 32'h1234_5678, 32'h8000_0000, 0};
        vecs[9] = '{3'd3, 32'hFFFF_FFFF, 32'd16,         1'b0, 32'h0000_000F, 32'h0FFF_FFFF, 10};

        reset        = 1'b1;
        mif.e_start  = 1'b0;
        mif.e_op     = 3'd0;
        mif.e_a      = 32'd0;
        mif.e_b      = 32'd0;
        mif.d_use_md = 1'b0;
`ifdef MDU_CANCEL_EN
        mif.cancel   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset busy", 32'(mif.busy), 32'd0);
        chk("reset hi", mif.hi, 32'd0);
        chk("reset lo", mif.lo, 32'd0);
        chk("reset stall", 32'(mif.stall_d), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].duse,
                   vecs[i].xhi, vecs[i].xlo, vecs[i].ncyc);
        end

        // A second start while running must not disturb the first op.
        mif.e_start = 1'b1; mif.e_op = 3'd0; mif.e_a = 32'd3; mif.e_b = 32'd4; mif.d_use_md = 1'b1;
        @(posedge clk); #1;
        mif.e_start = 1'b0;
        #1;
        for (int i = 0; i < c_MULT; i++) begin
            chk($sformatf("ignore busy c%0d", i), 32'(mif.busy), 32'd1);
            chk($sformatf("ignore hi stable c%0d", i), mif.hi, m_hi);
            @(posedge clk); #1;
            mif.e_start = (i == 0);
            mif.e_op = 3'd2; mif.e_a = 32'd100; mif.e_b = 32'd7;
            #1;
        end
        chk("ignore done busy", 32'(mif.busy), 32'd0);
        chk("ignore hi", mif.hi, 32'd0);
        chk("ignore lo", mif.lo, 32'd12);
        m_hi = 32'd0; m_lo = 32'd12;
        @(posedge clk); #2;
        chk("ignore stays idle", 32'(mif.busy), 32'd0);
        mif.d_use_md = 1'b0;

        // Prime nonzero hi/lo so the async reset is observable.
        run_op("pre-reset mthi", 3'd4, 32'hA5A5_0001, 32'd0, 1'b0, 32'hA5A5_0001, 32'd12, 0);
        mif.e_start = 1'b1; mif.e_op = 3'd2; mif.e_a = 32'd100; mif.e_b = 32'd7; mif.d_use_md = 1'b1;
        @(posedge clk); #1;
        mif.e_start = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async reset busy", 32'(mif.busy), 32'd0);
        chk("async reset hi", mif.hi, 32'd0);
        chk("async reset lo", mif.lo, 32'd0);
        chk("async reset stall", 32'(mif.stall_d), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op("post-reset mult", 3'd0, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, c_MULT);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            funct = 6'($urandom_range(0, 63));
            model(rop, ra, rb, rhi, rlo, rcyc);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, d_is_md_instr(6'd0, funct), rhi, rlo, rcyc);
        end

`ifdef MDU_CANCEL_EN
        mif.e_start = 1'b1; mif.e_op = 3'd0; mif.e_a = 32'd7; mif.e_b = 32'd9;
        @(posedge clk); #1;
        mif.e_start = 1'b0;
        @(posedge clk); #1;
        mif.cancel = 1'b1;
        @(posedge clk); #1;
        mif.cancel = 1'b0;
        #1;
        chk("cancel busy", 32'(mif.busy), 32'd0);
        chk("cancel hi", mif.hi, m_hi);
        chk("cancel lo", mif.lo, m_lo);
        mif.e_start = 1'b1; mif.e_op = 3'd5; mif.e_a = 32'hCAFE_F00D; mif.cancel = 1'b1;
        @(posedge clk); #1;
        mif.e_start = 1'b0; mif.cancel = 1'b0;
        #1;
        chk("cancel mtlo lo", mif.lo, m_lo);
        chk("cancel mtlo busy", 32'(mif.busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
